uart_rx_sequencer: RTL
======================

// Module: uart_rx_sequencer
// PURPOSE
//   Oversampled receive controller for the UART receive path. Sits between the serial pin (rx_in)
//   and the byte consumer. It detects and validates the start bit, paces mid-bit sampling from a
//   baud tick, and sequences the data shift, parity check and stop check.
//   It delivers each byte through a one-entry valid/ready holding register, together with
//   per-frame error flags and a sticky overrun flag.
// PARAMETERS
//   OVERSAMPLE  16  baud ticks per bit period; even, >=4
//   DATA_BITS   8   data bits per frame, LSB first; 5..8
//   PARITY_EN   1   1 = a parity bit follows the data bits
//   PARITY_ODD  0   0 = even parity, 1 = odd parity
// PORTS
//   rx_clock             in   1          single system clock
//   rx_reset             in   1          synchronous, active-low reset
//   rx_baud_tick         in   1          1-cycle enable; OVERSAMPLE ticks per bit
//   rx_in                in   1          asynchronous serial line, idle high
//   rx_shift             out  1          1-cycle strobe at each data-bit sample point
//   rx_sample            out  1          synchronized line value; qualified by rx_shift
//   data_out_rx          out  DATA_BITS  held received byte
//   rx_valid             out  1          data_out_rx and error flags valid
//   rx_ready             in   1          consumer accepts; handshake = rx_valid & rx_ready
//   rx_parity_bit_error  out  1          parity mismatch for the held byte
//   stop_bit_error       out  1          stop bit sampled low for the held byte
//   rx_overrun           out  1          sticky: a frame completed while the register was full
//   rx_busy              out  1          state != IDLE
// BEHAVIOUR
//   - Reset (rx_reset=0 at a rising edge) applies on that edge, including mid-frame.
//     All outputs go to 0, data_out_rx = 0, the synchronizer is preset to 1, state = IDLE
//     with the receiver armed. Any in-flight frame is discarded with no flags.
//   - rx_in passes through a 2-flop synchronizer (2-cycle latency). All decisions use the
//     synchronized value. The counters advance only on cycles where rx_baud_tick = 1.
//   - sc = sample counter, 0..OVERSAMPLE-1. bc = bit counter, 0..DATA_BITS-1.
//   - IDLE: on a tick, if armed and the line is low -> START, sc=0.
//   - START: on a tick at sc = OVERSAMPLE/2-1 (mid start bit):
//       line high -> IDLE (glitch, no flags, no strobe);
//       line low  -> DATA, sc=0, bc=0. Otherwise sc++.
//   - DATA: on a tick at sc = OVERSAMPLE-1 (mid-bit):
//       pulse rx_shift for 1 cycle and shift the line value into bit[bc]; sc=0;
//       after DATA_BITS bits -> PARITY if PARITY_EN, else STOP; otherwise bc++.
//   - PARITY: at the same mid-bit point, capture
//       perr = (line != (^data ^ PARITY_ODD)); then -> STOP.
//   - STOP: at the mid-bit point, capture ferr = !line, commit the frame, then -> IDLE.
//       If ferr = 1, the receiver is disarmed until the line is sampled high
//       (prevents a re-trigger on a held-low line).
//   - Commit (single cycle; a handshake in the same cycle is seen first):
//       * register empty, or being emptied by a handshake this cycle:
//           load data/perr/ferr and set rx_valid=1. The byte is delivered even with errors.
//       * register full and not handshaking: the new frame is dropped, the held byte and
//           flags are unchanged, rx_overrun <= 1.
//   - Handshake without a commit: rx_valid <= 0 on the next edge.
//       data_out_rx and the error flags hold their last values.
//   - Any handshake clears rx_overrun. A commit-to-full sets it, and set wins if both happen
//     in the same cycle.
//   - rx_valid is never deasserted without a handshake. data_out_rx is stable while rx_valid=1.
//   - Frame-to-valid latency: rx_valid rises 1 cycle after the mid-stop tick.
// TESTING  (OVERSAMPLE=16, DATA_BITS=8, PARITY_EN=1 even, rx_baud_tick=1 every cycle)
//   1. Frame 0xA5, parity 0, stop 1, rx_ready=1
//        -> 8 rx_shift pulses 16 cycles apart; rx_valid for 1 cycle; data 0xA5; both errors 0.
//   2. rx_in low for 4 cycles, then high
//        -> enters START, returns to IDLE; no rx_shift, no rx_valid.
//   3. Frame 0x01 with parity bit 0
//        -> rx_valid, data 0x01, rx_parity_bit_error=1, stop_bit_error=0.
//   4. Frame 0x3C with stop bit low, line held low 40 cycles
//        -> stop_bit_error=1; no new START until the line is high.
//   5. rx_ready=0; frames 0x11 then 0x22
//        -> data stays 0x11, rx_overrun=1; raise rx_ready -> handshake, rx_overrun=0.
//   6. Reset asserted at the 3rd data bit of frame 0x5A
//        -> next edge all outputs 0, rx_busy=0; a clean 0x5A after release is received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// Oversampled UART receive controller: start-bit validation, mid-bit sampling, parity/stop
// checks and a one-entry valid/ready holding register with per-frame error flags.
module uart_rx_sequencer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 rx_clock,
    input  logic                 rx_reset,
    input  logic                 rx_baud_tick,
    input  logic                 rx_in,
    output logic                 rx_shift,
    output logic                 rx_sample,
    output logic [DATA_BITS-1:0] data_out_rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_bit_error,
    output logic                 stop_bit_error,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned ScW = $clog2(OVERSAMPLE);
    localparam int unsigned BcW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [ScW-1:0] ScMid  = ScW'(OVERSAMPLE / 2 - 1);
    localparam logic [ScW-1:0] ScEnd  = ScW'(OVERSAMPLE - 1);
    localparam logic [BcW-1:0] BcLast = BcW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [ScW-1:0]       sc_q, sc_d;
    logic [BcW-1:0]       bc_q, bc_d;
    logic                 sync1_q, sync2_q;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 frame_perr_q, frame_perr_d;
    logic                 strobe, commit, frame_ferr;
    logic                 line;

    logic                 shift_q, sample_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 hs, load, drop;

    assign line = sync2_q;

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bc_d         = bc_q;
        shreg_d      = shreg_q;
        frame_perr_d = frame_perr_q;
        armed_d      = armed_q | line;
        strobe       = 1'b0;
        commit       = 1'b0;
        frame_ferr   = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_baud_tick && armed_q && !line) begin
                    state_d = StStart;
                    sc_d    = '0;
                end
            end
            StStart: begin
                if (rx_baud_tick) begin
                    if (sc_q == ScMid) begin
                        if (line) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            sc_d    = '0;
                            bc_d    = '0;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (rx_baud_tick) begin
                    if (sc_q == ScEnd) begin
                        strobe        = 1'b1;
                        shreg_d[bc_q] = line;
                        sc_d          = '0;
                        if (bc_q == BcLast) begin
                            state_d = PARITY_EN ? StParity : StStop;
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (rx_baud_tick) begin
                    if (sc_q == ScEnd) begin
                        frame_perr_d = line != (^shreg_q ^ PARITY_ODD);
                        sc_d         = '0;
                        state_d      = StStop;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (rx_baud_tick) begin
                    if (sc_q == ScEnd) begin
                        commit     = 1'b1;
                        frame_ferr = !line;
                        state_d    = StIdle;
                        // A low stop bit disarms until the line returns high.
                        if (!line) armed_d = 1'b0;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register; a same-cycle handshake frees the slot before the commit lands.
    always_comb begin
        hs        = valid_q & rx_ready;
        load      = commit & (!valid_q | hs);
        drop      = commit & valid_q & !hs;
        valid_d   = load ? 1'b1 : (hs ? 1'b0 : valid_q);
        data_d    = load ? shreg_q : data_q;
        perr_d    = load ? frame_perr_q : perr_q;
        ferr_d    = load ? frame_ferr : ferr_q;
        overrun_d = drop ? 1'b1 : (hs ? 1'b0 : overrun_q);
    end

    always_ff @(posedge rx_clock) begin
        if (!rx_reset) begin
            state_q      <= StIdle;
            sc_q         <= '0;
            bc_q         <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            armed_q      <= 1'b1;
            shreg_q      <= '0;
            frame_perr_q <= 1'b0;
            shift_q      <= 1'b0;
            sample_q     <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bc_q         <= bc_d;
            sync1_q      <= rx_in;
            sync2_q      <= sync1_q;
            armed_q      <= armed_d;
            shreg_q      <= shreg_d;
            frame_perr_q <= frame_perr_d;
            shift_q      <= strobe;
            if (strobe) sample_q <= line;
            data_q       <= data_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_shift            = shift_q;
    assign rx_sample           = sample_q;
    assign data_out_rx         = data_q;
    assign rx_valid            = valid_q;
    assign rx_parity_bit_error = perr_q;
    assign stop_bit_error      = ferr_q;
    assign rx_overrun          = overrun_q;
    assign rx_busy             = (state_q != StIdle);

endmodule
